// File: rtl/pool_pkg.sv
// Shared constants and width helpers for the multi-channel pooling execute stage.
// The average datapath is present only when POOL_AVG_EN is defined.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A sum of WIN lanes needs log2(WIN) guard bits above the lane width.
  function automatic int acc_width(input int dw, input int win);
    return dw + clog2(win);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: accumulator, max/avg update and result, driven by shared control.
// POOL_AVG_EN builds the wide average accumulator; otherwise the lane is max-only and DW wide.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DW  = 16,
  parameter int WIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_upd,
  input  logic          i_mode,
  input  logic [DW-1:0] i_x,
  output logic [DW-1:0] o_res
);

`ifdef POOL_AVG_EN
  localparam int AW = acc_width(DW, WIN);
  localparam int LW = clog2(WIN);

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_x;
  logic signed [AW-1:0] w_nxt;
  logic        [DW-1:0] w_avg;

  assign w_x = {{LW{i_x[DW-1]}}, i_x};

  always_comb begin
    w_nxt = r_acc;
    if (i_load) begin
      w_nxt = w_x;
    end else if (i_upd) begin
      if (i_mode == POOL_AVG) w_nxt = r_acc + w_x;
      else if (w_x > r_acc)   w_nxt = w_x;
    end
  end

  // Arithmetic shift gives floor division toward -inf.
  assign w_avg = DW'(w_nxt >>> LW);
  assign o_res = (i_mode == POOL_AVG) ? w_avg : w_nxt[DW-1:0];
`else
  logic signed [DW-1:0] r_acc;
  logic signed [DW-1:0] w_x;
  logic signed [DW-1:0] w_nxt;
  logic                 w_unused_mode;

  assign w_unused_mode = i_mode;
  assign w_x           = i_x;

  always_comb begin
    w_nxt = r_acc;
    if (i_load) begin
      w_nxt = w_x;
    end else if (i_upd) begin
      if (w_x > r_acc) w_nxt = w_x;
    end
  end

  assign o_res = w_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load || i_upd) begin
      r_acc <= w_nxt;
    end
  end

endmodule

// File: rtl/pool_exec_multi.sv
// Multi-channel pooling execute stage: reduces WIN beats per lane to one max/avg result.
// Define POOL_AVG_EN to build the average datapath; otherwise mode is ignored and max is used.
module pool_exec_multi
  import pool_pkg::*;
#(
  parameter int CH  = 6,
  parameter int DW  = 16,
  parameter int WIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pool_clr,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data
);

  localparam int            CW   = clog2(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic             r_out_valid;
  logic [CH*DW-1:0] r_out_data;
  logic [CH*DW-1:0] w_res;
  logic             w_mode_in;
  logic             w_acc;
  logic             w_first;
  logic             w_last;

`ifdef POOL_AVG_EN
  assign w_mode_in = mode;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_mode_in     = POOL_MAX;
`endif

  // Handshake: a beat moves when in_valid && in_ready; a result moves when out_valid && out_ready.
  // Only the closing beat of a window stalls, and only while the output register is still held.
  assign in_ready = !(r_out_valid && !out_ready && (r_cnt == LAST));
  assign w_acc    = in_valid && in_ready && !pool_clr;
  assign w_first  = w_acc && (r_cnt == '0);
  assign w_last   = w_acc && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mode <= POOL_MAX;
    end else if (pool_clr) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : CW'(r_cnt + 1'b1);
      if (r_cnt == '0) r_mode <= w_mode_in;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    pool_lane #(
      .DW  (DW),
      .WIN (WIN)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (pool_clr),
      .i_load (w_first),
      .i_upd  (w_acc && !w_first),
      .i_mode (r_mode),
      .i_x    (in_data[DW*g +: DW]),
      .o_res  (w_res[DW*g +: DW])
    );
  end

  // A window closing in the same cycle the held result is taken keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (pool_clr) begin
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_pool_exec_multi.sv
// Scoreboard bench for pool_exec_multi: a window-level reference model pushes expected results,
// an output monitor pops and compares them on every accepted result.
module tb_pool_exec_multi;
  import pool_pkg::*;

  localparam int CH  = 6;
  localparam int DW  = 16;
  localparam int WIN = 4;
  localparam int W   = CH * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pool_clr = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  bit rand_rdy = 1'b0;

  // reference model state
  int           beats[CH][WIN];
  int           nb = 0;
  logic         wmode = 1'b0;
  bit           full = 1'b0;
  bit           done;
  int           m, s, q;
  logic [W-1:0] ev;
  logic [W-1:0] popped;

  pool_exec_multi #(.CH(CH), .DW(DW), .WIN(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .pool_clr  (pool_clr),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  // reference model: sees every accepted beat, emits the expected window result
  always @(negedge clk) begin
    if (rst) begin
      nb   = 0;
      full = 1'b0;
      exp_q.delete();
    end else begin
      chk("out_valid", W'(out_valid), W'(full));
      chk("in_ready", W'(in_ready), W'(!(full && !out_ready && nb == WIN - 1)));
      if (pool_clr) begin
        nb   = 0;
        full = 1'b0;
        exp_q.delete();
      end else begin
        done = 1'b0;
        if (in_valid && in_ready) begin
`ifdef POOL_AVG_EN
          if (nb == 0) wmode = mode;
`else
          if (nb == 0) wmode = POOL_MAX;
`endif
          for (int l = 0; l < CH; l++) beats[l][nb] = int'($signed(in_data[DW*l +: DW]));
          nb++;
          if (nb == WIN) begin
            for (int l = 0; l < CH; l++) begin
              m = beats[l][0];
              s = 0;
              for (int k = 0; k < WIN; k++) begin
                if (beats[l][k] > m) m = beats[l][k];
                s += beats[l][k];
              end
              q = s / WIN;
              if ((s % WIN != 0) && (s < 0)) q = q - 1;
              ev[DW*l +: DW] = (wmode == POOL_AVG) ? DW'(q) : DW'(m);
            end
            exp_q.push_back(ev);
            nb   = 0;
            done = 1'b1;
          end
        end
        if (done) full = 1'b1;
        else if (full && out_ready) full = 1'b0;
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out act=%h exp=none @%0t", out_data, $time);
      end else begin
        popped = exp_q.pop_front();
        chk("out_data", out_data, popped);
      end
    end
  end

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] mk(input int a, input int b);
    logic [W-1:0] d;
    for (int l = 0; l < CH; l++) d[DW*l +: DW] = rnd_val();
    d[0 +: DW]  = DW'(a);
    d[DW +: DW] = DW'(b);
    return d;
  endfunction

  function automatic logic [W-1:0] mk_rand();
    logic [W-1:0] d;
    for (int l = 0; l < CH; l++) d[DW*l +: DW] = rnd_val();
    return d;
  endfunction

  // driver tasks
  task automatic send_beat(input logic [W-1:0] d, input logic m_in);
    bit ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m_in;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout act=stalled exp=accepted @%0t", $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1;
    rand_rdy  = 1'b0;
    out_ready = 1'b0;
    pool_clr  = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = mk_rand();
    @(posedge clk);
    #1;
    pool_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [W-1:0] d2;
  int           vcount;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));

    // max window
    send_beat(mk(3, -1), POOL_MAX);
    send_beat(mk(-5, -8), POOL_MAX);
    send_beat(mk(7, -3), POOL_MAX);
    send_beat(mk(2, -2), POOL_MAX);
    idle(1);
    @(negedge clk);
    chk("t1_valid", W'(out_valid), W'(1'b1));
    chk("t1_lane0", W'(out_data[0 +: DW]), W'(16'd7));
    chk("t1_lane1", W'(out_data[DW +: DW]), W'(16'hFFFF));
    idle(2);

    // average window (max-only build ignores mode)
    d2 = mk(4, -1); d2[2*DW +: DW] = 16'h7FFF; send_beat(d2, POOL_AVG);
    d2 = mk(5, -2); d2[2*DW +: DW] = 16'h7FFF; send_beat(d2, POOL_AVG);
    d2 = mk(6, -2); d2[2*DW +: DW] = 16'h7FFF; send_beat(d2, POOL_AVG);
    d2 = mk(7, -2); d2[2*DW +: DW] = 16'h7FFF; send_beat(d2, POOL_AVG);
    idle(1);
    @(negedge clk);
`ifdef POOL_AVG_EN
    chk("t2_lane0", W'(out_data[0 +: DW]), W'(16'd5));
    chk("t2_lane1", W'(out_data[DW +: DW]), W'(16'hFFFE));
`else
    chk("t2_lane0", W'(out_data[0 +: DW]), W'(16'd7));
    chk("t2_lane1", W'(out_data[DW +: DW]), W'(16'hFFFF));
`endif
    chk("t2_lane2", W'(out_data[2*DW +: DW]), W'(16'h7FFF));
    idle(2);

    // backpressure: closing beat of window B stalls while A is held
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < WIN; i++) send_beat(mk_rand(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < WIN - 1; i++) send_beat(mk_rand(), 1'($urandom_range(0, 1)));
    fork
      send_beat(mk_rand(), 1'($urandom_range(0, 1)));
      begin
        repeat (3) @(negedge clk);
        chk("t3_stall", W'(in_ready), '0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(3);

    // streaming: two back-to-back windows, exactly two result cycles
    vcount = 0;
    fork
      begin
        for (int i = 0; i < 2 * WIN; i++) send_beat(mk_rand(), 1'($urandom_range(0, 1)));
        idle(1);
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (out_valid) vcount++;
        end
      end
    join
    chk("t4_valid_cycles", W'(vcount), W'(2));
    idle(2);

    // pool_clr with a result pending, then a fresh window with mode toggled mid-window
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < WIN + 2; i++) send_beat(mk_rand(), 1'($urandom_range(0, 1)));
    do_clr();
    @(negedge clk);
    chk("t5_clr_valid", W'(out_valid), '0);
    @(posedge clk); #1; out_ready = 1'b1;
    send_beat(mk_rand(), POOL_MAX);
    send_beat(mk_rand(), POOL_AVG);
    send_beat(mk_rand(), POOL_AVG);
    send_beat(mk_rand(), POOL_AVG);
    idle(3);

    // asynchronous reset mid-window with a result pending
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < WIN + 2; i++) send_beat(mk_rand(), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t6_rst_valid", W'(out_valid), '0);
    chk("t6_rst_data", out_data, '0);
    chk("t6_rst_ready", W'(in_ready), W'(1'b1));
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    idle(1);

    // random traffic
    rand_rdy = 1'b1;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 99)) inside
        [0:2]:  begin do_clr(); rand_rdy = 1'b1; end
        [3:14]: idle(1);
        default: send_beat(mk_rand(), 1'($urandom_range(0, 1)));
      endcase
    end
    idle(1);

    // drain
    rand_rdy = 1'b0;
    @(posedge clk); #3; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_left", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
